// File: rtl/signal_pkg.sv
// Shared definitions for the signal conditioner: period FSM states and
// default parameter values.
package signal_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        MEAS = 1'b1
    } period_state_e;

    localparam int C_SYNC_STAGES_DEF = 2;
    localparam int C_FILT_DEF        = 8;
    localparam int C_PER_W_DEF       = 16;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flip-flop synchronizer bringing an asynchronous input into
// the clk domain; all stages reset to 0.
module sync_ff #(
    parameter int C_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [C_STAGES-1:0] chain_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[C_STAGES-2:0], d};
        end
    end

    assign q = chain_q[C_STAGES-1];

endmodule

// File: rtl/signal_conditioner.sv
// Synchronizes and deglitches an asynchronous input, flags its edges and
// measures the rise-to-rise period of the cleaned signal.
module signal_conditioner
    import signal_pkg::*;
#(
    parameter int C_SYNC_STAGES = C_SYNC_STAGES_DEF,
    parameter int C_FILT        = C_FILT_DEF,
    parameter int C_PER_W       = C_PER_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in,
    output logic               out,
    output logic               rise,
    output logic               fall,
    output logic [C_PER_W-1:0] period,
    output logic               period_valid,
    output logic               period_ovf
);

    localparam int FW = (C_FILT > 1) ? $clog2(C_FILT) : 1;
    localparam logic [FW-1:0]      FILT_LAST = FW'(C_FILT - 1);
    localparam logic [C_PER_W-1:0] PCNT_MAX  = '1;
    localparam logic [C_PER_W-1:0] PCNT_ONE  = C_PER_W'(1);

    logic               sync;
    logic [FW-1:0]      filtCnt_q, filtCnt_d;
    logic               out_q, out_d;
    logic               rise_q, rise_d;
    logic               fall_q, fall_d;
    period_state_e      state_q, state_d;
    logic [C_PER_W-1:0] pcnt_q, pcnt_d;
    logic [C_PER_W-1:0] period_q, period_d;
    logic               valid_q, valid_d;
    logic               ovf_q, ovf_d;

    sync_ff #(
        .C_STAGES(C_SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (in),
        .q    (sync)
    );

    // The counter measures how long sync has disagreed with out; the edge
    // pulses are produced together with the toggle so they line up with out.
    always_comb begin
        filtCnt_d = '0;
        out_d     = out_q;
        rise_d    = 1'b0;
        fall_d    = 1'b0;
        if (sync != out_q) begin
            if (filtCnt_q == FILT_LAST) begin
                out_d  = ~out_q;
                rise_d = ~out_q;
                fall_d = out_q;
            end else begin
                filtCnt_d = filtCnt_q + FW'(1);
            end
        end
    end

    // The counter holds at all-ones once saturated, so a rise seeing that
    // value reports an overflowed interval instead of a period.
    always_comb begin
        state_d  = state_q;
        pcnt_d   = pcnt_q;
        period_d = period_q;
        valid_d  = 1'b0;
        ovf_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise_q) begin
                    state_d = MEAS;
                    pcnt_d  = PCNT_ONE;
                end
            end
            MEAS: begin
                if (rise_q) begin
                    if (pcnt_q == PCNT_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        period_d = pcnt_q;
                        valid_d  = 1'b1;
                    end
                    pcnt_d = PCNT_ONE;
                end else if (pcnt_q != PCNT_MAX) begin
                    pcnt_d = pcnt_q + PCNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filtCnt_q <= '0;
            out_q     <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            state_q   <= IDLE;
            pcnt_q    <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            filtCnt_q <= filtCnt_d;
            out_q     <= out_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            state_q   <= state_d;
            pcnt_q    <= pcnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
        end
    end

    assign out          = out_q;
    assign rise         = rise_q;
    assign fall         = fall_q;
    assign period       = period_q;
    assign period_valid = valid_q;
    assign period_ovf   = ovf_q;

endmodule

// File: tb/tb_signal_conditioner.sv
// Self-checking bench for signal_conditioner: directed scenarios plus random
// level runs, compared each cycle against a sample-history reference model.
module tb_signal_conditioner;

    localparam int S = 2;
    localparam int F = 4;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         inSig;
    logic         out, rise, fall, periodValid, periodOvf;
    logic [W-1:0] period;

    int total = 0;
    int bad   = 0;

    signal_conditioner #(
        .C_SYNC_STAGES(S),
        .C_FILT       (F),
        .C_PER_W      (W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in          (inSig),
        .out         (out),
        .rise        (rise),
        .fall        (fall),
        .period      (period),
        .period_valid(periodValid),
        .period_ovf  (periodOvf)
    );

    always #25 clk = ~clk;

    // Reference model: out follows sync only after F identical samples that
    // differ from it; periods come from timestamps of the expected rises.
    bit           inHist[$];
    bit           mOut, mRise, mFall, mValid, mOvf;
    logic [W-1:0] mPeriod;
    bit           pendValid, pendOvf, haveRise;
    int           pendPeriod, lastRise, edgeNo;

    function automatic bit histAt(input int d);
        int idx;
        idx = inHist.size() - 1 - d;
        return (idx >= 0) ? inHist[idx] : 1'b0;
    endfunction

    task automatic modelClear();
        inHist.delete();
        mOut = 0; mRise = 0; mFall = 0; mValid = 0; mOvf = 0;
        mPeriod = '0; pendValid = 0; pendOvf = 0; haveRise = 0;
    endtask

    task automatic modelEdge();
        bit v, allSame, prev;
        int interval;
        edgeNo++;
        inHist.push_back(inSig);
        mValid = pendValid;
        mOvf   = pendOvf;
        if (pendValid) mPeriod = W'(pendPeriod);
        pendValid = 0;
        pendOvf   = 0;
        v = histAt(S);
        allSame = 1;
        for (int j = 1; j < F; j++) if (histAt(S + j) != v) allSame = 0;
        prev = mOut;
        if (allSame && v != mOut) mOut = v;
        mRise = mOut & ~prev;
        mFall = ~mOut & prev;
        if (mRise) begin
            if (haveRise) begin
                interval = edgeNo - lastRise;
                if (interval >= (1 << W) - 1) pendOvf = 1;
                else begin
                    pendValid  = 1;
                    pendPeriod = interval;
                end
            end
            haveRise = 1;
            lastRise = edgeNo;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, edgeNo, obs, exp);
        end
    endtask

    task automatic checkOutput();
        chk("out", 32'(out), 32'(mOut));
        chk("rise", 32'(rise), 32'(mRise));
        chk("fall", 32'(fall), 32'(mFall));
        chk("period", 32'(period), 32'(mPeriod));
        chk("period_valid", 32'(periodValid), 32'(mValid));
        chk("period_ovf", 32'(periodOvf), 32'(mOvf));
    endtask

    task automatic checkAllZero(input string tag);
        chk({tag, ".out"}, 32'(out), 32'd0);
        chk({tag, ".rise"}, 32'(rise), 32'd0);
        chk({tag, ".fall"}, 32'(fall), 32'd0);
        chk({tag, ".period"}, 32'(period), 32'd0);
        chk({tag, ".period_valid"}, 32'(periodValid), 32'd0);
        chk({tag, ".period_ovf"}, 32'(periodOvf), 32'd0);
    endtask

    // Entered and left just after a falling edge.
    task automatic applyStimulus(input bit v);
        inSig = v;
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput();
        @(negedge clk);
    endtask

    task automatic holdLevel(input bit v, input int n);
        for (int i = 0; i < n; i++) applyStimulus(v);
    endtask

    task automatic resetPulse();
        #5 reset = 1'b1;
        #1 modelClear();
        checkAllZero("reset_async");
        @(posedge clk);
        #1 checkAllZero("reset_held");
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int latency;
        int len;
        bit lvl;
        $display("[TB] signal_conditioner bench start");
        reset = 1'b1;
        inSig = 1'b0;
        edgeNo = 0;
        modelClear();
        #10 checkAllZero("reset_init");
        @(negedge clk);
        reset = 1'b0;

        holdLevel(1'b0, 10);
        latency = 0;
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(1'b1);
            if (latency == 0 && out === 1'b1) latency = i;
        end
        chk("first_rise_latency", 32'(latency), 32'(S + F));

        holdLevel(1'b0, 12);
        holdLevel(1'b1, 3);
        holdLevel(1'b0, 12);
        holdLevel(1'b1, 4);
        holdLevel(1'b0, 12);

        for (int p = 0; p < 5; p++) begin
            holdLevel(1'b1, 20);
            holdLevel(1'b0, 20);
        end

        holdLevel(1'b1, 20);
        holdLevel(1'b0, 280);
        holdLevel(1'b1, 20);
        holdLevel(1'b0, 20);
        holdLevel(1'b1, 20);
        holdLevel(1'b0, 20);

        for (int p = 0; p < 2; p++) begin
            holdLevel(1'b1, 20);
            holdLevel(1'b0, 20);
        end
        holdLevel(1'b1, 10);
        resetPulse();
        holdLevel(1'b1, 10);
        holdLevel(1'b0, 20);
        for (int p = 0; p < 3; p++) begin
            holdLevel(1'b1, 20);
            holdLevel(1'b0, 20);
        end

        lvl = 1'b0;
        for (int s = 0; s < 25; s++) begin
            lvl = ~lvl;
            len = int'($urandom_range(1, 30));
            holdLevel(lvl, len);
        end
        holdLevel(1'b0, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/signal_conditioner.md
SIGNAL_CONDITIONER -- requirements
Module: signal_conditioner

Interface
REQ-001 Parameter C_SYNC_STAGES, default 2, SHALL set the synchronizer depth for in (legal 2..4).
REQ-002 Parameter C_FILT, default 8, SHALL set the consecutive stable samples needed to accept a new level (legal 1..255).
REQ-003 Parameter C_PER_W, default 16, SHALL set the period counter and period output width (legal 4..32).
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  SHALL be the reset: asynchronous assert, active-high.
REQ-006 in  input  1  SHALL be the raw asynchronous signal to condition.
REQ-007 out  output  1  SHALL be the synchronized, deglitched level of in; it feeds the downstream presence detector.
REQ-008 rise  output  1  SHALL be a one-cycle pulse on each 0->1 change of out.
REQ-009 fall  output  1  SHALL be a one-cycle pulse on each 1->0 change of out.
REQ-010 period  output  C_PER_W  SHALL hold the last measured rise-to-rise interval in clk cycles.
REQ-011 period_valid  output  1  SHALL be a one-cycle pulse when period is updated.
REQ-012 period_ovf  output  1  SHALL be a one-cycle pulse when a rise ends an interval that saturated the counter.

Function
REQ-013 in SHALL pass through a C_SYNC_STAGES flip-flop chain; only the last stage (sync) SHALL be used downstream.
REQ-014 Filter counter SHALL increment each cycle sync != out and clear to 0 in any cycle sync == out.
REQ-015 When the filter counter would reach C_FILT, out SHALL toggle on that edge and the counter SHALL clear.
REQ-016 With C_FILT=1, out SHALL follow sync with one cycle delay.
REQ-017 A clean level change on in SHALL appear on out at the (C_SYNC_STAGES+C_FILT)th rising edge, counting the first edge that samples the new level as edge 1.
REQ-018 Pulses on in shorter than C_FILT cycles at sync SHALL NOT change out.
REQ-019 rise/fall SHALL be registered and asserted in exactly the cycle out first shows the new value; never both in one cycle.
REQ-020 Period FSM SHALL have states IDLE (no rise since reset) and MEAS.
REQ-021 IDLE: on rise, go to MEAS, load pcnt=1, assert neither period_valid nor period_ovf.
REQ-022 MEAS, no rise: pcnt SHALL increment, saturating at 2^C_PER_W-1 (no wrap).
REQ-023 MEAS, rise with pcnt unsaturated: period<=pcnt, pulse period_valid, pcnt<=1.
REQ-024 MEAS, rise with pcnt saturated: period unchanged, pulse period_ovf, pcnt<=1, stay MEAS.
REQ-025 fall SHALL NOT affect the period FSM.

Reset
REQ-026 While reset is high: sync chain, out, rise, fall, period, period_valid, period_ovf, filter counter and pcnt SHALL be 0 and the FSM SHALL be IDLE.
REQ-027 Reset asserted mid-measurement SHALL discard the interval in progress; the first rise after release SHALL NOT pulse period_valid.
REQ-028 Reset release SHALL not by itself produce rise, fall or period_valid.

Structure
REQ-029 Package signal_pkg SHALL hold the FSM state enum (IDLE, MEAS) and default parameter constants.
REQ-030 The synchronizer chain SHALL be sub-module sync_ff (parameter C_STAGES, ports clk, reset, d, q), reset value 0.
REQ-031 Filter, edge detection and period FSM SHALL reside in signal_conditioner itself.

Verification (C_SYNC_STAGES=2, C_FILT=4, C_PER_W=8, clk 50 ns)
REQ-032 Reset, then in 0->1 held -> out=1 at 6th edge after in sampled; rise high exactly 1 cycle; fall never.
REQ-033 in high for 3 cycles then low -> out stays 0, no rise/fall; 4-cycle pulse -> out high 4 cycles, one rise, one fall.
REQ-034 Square wave, 20 cycles high / 20 low, 5 periods -> no period_valid on 1st rise; period=40 with period_valid on each later rise.
REQ-035 Two rises 300 cycles apart -> period_ovf one pulse, period keeps prior value, period_valid not asserted; next 40-cycle interval -> period=40.
REQ-036 Reset pulsed during a 40-cycle square wave -> all outputs 0 immediately; first rise after release gives no period_valid, second gives period=40.
